pc_control_unit: RTL and testbench

PC_CONTROL_UNIT -- requirements
Module: pc_control_unit

---
 rtl/pc_control_unit.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_pc_control_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_control_unit.sv
// ---------------------------------------------------------------------------
// pc_control_unit
//
// Program counter, instruction decoder and run/halt sequencer for a small
// single-cycle ARMv8 subset core. The instruction word fetched at instr_addr
// is decoded combinationally into datapath control signals; the PC, the
// run/halt state and the retired-instruction counter are registered.
//
// Ports
//   clk             in   1   sole clock, rising edge
//   reset           in   1   synchronous, active-high
//   Instruction     in  32   instruction word located at instr_addr
//   instr_addr      out 64   current program counter
//   negativeAlu     in   1   registered N flag from the datapath
//   zeroAlu         in   1   registered Z flag from the datapath
//   overflowAlu     in   1   registered V flag from the datapath
//   carryOutAlu     in   1   registered C flag (no supported condition uses it)
//   zeroCurr        in   1   unregistered ALU zero, used by CBZ
//   Reg2Loc         out  1   1: second read port reads Rm, 0: reads Rd
//   ALUSrc          out  1   low bit of the operand-B select
//   imm12Cntrl      out  1   high bit of the operand-B select
//   movKCntrl       out  1   MOVK keep-and-insert path enable
//   MemtoReg        out  1   write-back takes memory data
//   RegWrite        out  1   register file write enable
//   write_enable    out  1   data memory write
//   read_enable     out  1   data memory read
//   byteLoader      out  1   1 for full 64-bit load, 0 for byte load
//   flagSignal      out  1   datapath captures ALU flags this cycle
//   ALUop           out  3   000 pass-B, 010 add, 011 subtract
//   xfer_size       out  4   memory transfer size in bytes (0 when idle)
//   halted          out  1   high while the sequencer sits in HALT
//   instr_count     out 32   retired instruction count, saturating
// ---------------------------------------------------------------------------
module pc_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction,
    output logic [63:0] instr_addr,
    input  logic        negativeAlu,
    input  logic        zeroAlu,
    input  logic        overflowAlu,
    input  logic        carryOutAlu,
    input  logic        zeroCurr,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        imm12Cntrl,
    output logic        movKCntrl,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        write_enable,
    output logic        read_enable,
    output logic        byteLoader,
    output logic        flagSignal,
    output logic [2:0]  ALUop,
    output logic [3:0]  xfer_size,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_ADDI,
        OP_ADDS,
        OP_SUBS,
        OP_LDUR,
        OP_LDURB,
        OP_STUR,
        OP_STURB,
        OP_MOVZ,
        OP_MOVK,
        OP_B,
        OP_BCOND,
        OP_CBZ
    } op_t;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;

    state_t      state;
    logic        halted_q;
    logic [63:0] pc;
    logic [31:0] count;

    op_t         op;
    logic        decoded;
    logic        cond_taken;
    logic        branch_taken;
    logic [63:0] imm26_offset;
    logic [63:0] imm19_offset;
    logic [63:0] pc_next;

    // Raw decode outputs before run/halt and reset qualification.
    logic        dec_reg2loc;
    logic        dec_alusrc;
    logic        dec_imm12;
    logic        dec_movk;
    logic        dec_memtoreg;
    logic        dec_regwrite;
    logic        dec_write;
    logic        dec_read;
    logic        dec_byteloader;
    logic        dec_flags;
    logic [2:0]  dec_aluop;
    logic [3:0]  dec_xfer;

    // The carry flag arrives with the other flags but no supported
    // condition code needs it.
    logic unused_carry;
    assign unused_carry = carryOutAlu;

    // Opcode classification. Field widths differ per format, so each match
    // looks at exactly the bits that identify that instruction; the
    // encodings do not overlap, so the order of the tests is immaterial.
    always_comb begin
        op = OP_NONE;
        if (Instruction[31:22] == 10'b1001000100)
            op = OP_ADDI;
        else if (Instruction[31:21] == 11'b10101011000)
            op = OP_ADDS;
        else if (Instruction[31:21] == 11'b11101011000)
            op = OP_SUBS;
        else if (Instruction[31:21] == 11'b11111000010)
            op = OP_LDUR;
        else if (Instruction[31:21] == 11'b00111000010)
            op = OP_LDURB;
        else if (Instruction[31:21] == 11'b11111000000)
            op = OP_STUR;
        else if (Instruction[31:21] == 11'b00111000000)
            op = OP_STURB;
        else if (Instruction[31:23] == 9'b110100101)
            op = OP_MOVZ;
        else if (Instruction[31:23] == 9'b111100101)
            op = OP_MOVK;
        else if (Instruction[31:26] == 6'b000101)
            op = OP_B;
        else if (Instruction[31:24] == 8'b01010100)
            op = OP_BCOND;
        else if (Instruction[31:24] == 8'b10110100)
            op = OP_CBZ;
    end

    assign decoded = (op != OP_NONE);

    // Control word per opcode. Everything defaults to zero so that any
    // signal an instruction does not need stays inactive.
    always_comb begin
        dec_reg2loc    = 1'b0;
        dec_alusrc     = 1'b0;
        dec_imm12      = 1'b0;
        dec_movk       = 1'b0;
        dec_memtoreg   = 1'b0;
        dec_regwrite   = 1'b0;
        dec_write      = 1'b0;
        dec_read       = 1'b0;
        dec_byteloader = 1'b0;
        dec_flags      = 1'b0;
        dec_aluop      = ALU_PASS_B;
        dec_xfer       = 4'd0;
        case (op)
            OP_ADDI: begin
                dec_imm12    = 1'b1;
                dec_aluop    = ALU_ADD;
                dec_regwrite = 1'b1;
            end
            OP_ADDS: begin
                dec_reg2loc  = 1'b1;
                dec_aluop    = ALU_ADD;
                dec_regwrite = 1'b1;
                dec_flags    = 1'b1;
            end
            OP_SUBS: begin
                dec_reg2loc  = 1'b1;
                dec_aluop    = ALU_SUB;
                dec_regwrite = 1'b1;
                dec_flags    = 1'b1;
            end
            OP_LDUR: begin
                dec_alusrc     = 1'b1;
                dec_aluop      = ALU_ADD;
                dec_read       = 1'b1;
                dec_memtoreg   = 1'b1;
                dec_regwrite   = 1'b1;
                dec_xfer       = 4'd8;
                dec_byteloader = 1'b1;
            end
            OP_LDURB: begin
                dec_alusrc   = 1'b1;
                dec_aluop    = ALU_ADD;
                dec_read     = 1'b1;
                dec_memtoreg = 1'b1;
                dec_regwrite = 1'b1;
                dec_xfer     = 4'd1;
            end
            OP_STUR: begin
                dec_alusrc = 1'b1;
                dec_aluop  = ALU_ADD;
                dec_write  = 1'b1;
                dec_xfer   = 4'd8;
            end
            OP_STURB: begin
                dec_alusrc = 1'b1;
                dec_aluop  = ALU_ADD;
                dec_write  = 1'b1;
                dec_xfer   = 4'd1;
            end
            OP_MOVZ: begin
                dec_imm12    = 1'b1;
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
            end
            OP_MOVK: begin
                dec_movk     = 1'b1;
                dec_regwrite = 1'b1;
            end
            default: begin
                // B, B.cond and CBZ only need the ALU to pass Rt through
                // (CBZ) or nothing at all; the zero defaults cover them.
            end
        endcase
    end

    // Condition evaluation on the registered flags. The datapath registers
    // flags on the same edge that retires ADDS/SUBS, so a following B.cond
    // already sees them here.
    always_comb begin
        cond_taken = 1'b0;
        case (Instruction[4:0])
            5'b00000: cond_taken = zeroAlu;
            5'b00001: cond_taken = !zeroAlu;
            5'b01010: cond_taken = (negativeAlu == overflowAlu);
            5'b01011: cond_taken = (negativeAlu != overflowAlu);
            5'b01100: cond_taken = !zeroAlu && (negativeAlu == overflowAlu);
            5'b01101: cond_taken = !(!zeroAlu && (negativeAlu == overflowAlu));
            default:  cond_taken = 1'b0;
        endcase
    end

    // Word offsets are sign-extended and scaled by four; the add wraps
    // naturally at 64 bits.
    assign imm26_offset = {{36{Instruction[25]}}, Instruction[25:0], 2'b00};
    assign imm19_offset = {{43{Instruction[23]}}, Instruction[23:5], 2'b00};

    always_comb begin
        branch_taken = 1'b0;
        pc_next      = pc + 64'd4;
        case (op)
            OP_B: begin
                branch_taken = 1'b1;
                pc_next      = pc + imm26_offset;
            end
            OP_BCOND: begin
                branch_taken = cond_taken;
                if (cond_taken)
                    pc_next = pc + imm19_offset;
            end
            OP_CBZ: begin
                branch_taken = zeroCurr;
                if (zeroCurr)
                    pc_next = pc + imm19_offset;
            end
            default: begin
                branch_taken = 1'b0;
            end
        endcase
    end

    // Sequencer: PC, retire counter and run/halt state. An undecoded word
    // moves to HALT without advancing the PC or the counter; only reset
    // leaves HALT, and reset overrides every other update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
            pc       <= 64'd0;
            count    <= 32'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (decoded) begin
                        pc <= pc_next;
                        if (count != 32'hFFFF_FFFF)
                            count <= count + 32'd1;
                    end else begin
                        state    <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    // Control outputs are only meaningful while running a decoded word.
    // The state-changing enables are additionally forced off during reset
    // so nothing is written while the core is being reinitialised.
    logic run_valid;
    logic write_ok;

    assign run_valid = (state == ST_RUN) && decoded;
    assign write_ok  = run_valid && !reset;

    assign Reg2Loc      = run_valid && dec_reg2loc;
    assign ALUSrc       = run_valid && dec_alusrc;
    assign imm12Cntrl   = run_valid && dec_imm12;
    assign movKCntrl    = run_valid && dec_movk;
    assign MemtoReg     = run_valid && dec_memtoreg;
    assign byteLoader   = run_valid && dec_byteloader;
    assign ALUop        = run_valid ? dec_aluop : ALU_PASS_B;
    assign xfer_size    = run_valid ? dec_xfer : 4'd0;

    assign RegWrite     = write_ok && dec_regwrite;
    assign write_enable = write_ok && dec_write;
    assign read_enable  = write_ok && dec_read;
    assign flagSignal   = write_ok && dec_flags;

    assign instr_addr  = pc;
    assign instr_count = count;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_control_unit
//
// Directed bench for pc_control_unit. Each task drives one scenario and
// compares the DUT against hand-computed values; a summary line closes the
// run.
// ---------------------------------------------------------------------------
module tb_pc_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] Instruction;
    logic [63:0] instr_addr;
    logic        negativeAlu;
    logic        zeroAlu;
    logic        overflowAlu;
    logic        carryOutAlu;
    logic        zeroCurr;
    logic        Reg2Loc;
    logic        ALUSrc;
    logic        imm12Cntrl;
    logic        movKCntrl;
    logic        MemtoReg;
    logic        RegWrite;
    logic        write_enable;
    logic        read_enable;
    logic        byteLoader;
    logic        flagSignal;
    logic [2:0]  ALUop;
    logic [3:0]  xfer_size;
    logic        halted;
    logic [31:0] instr_count;

    int checks;
    int fails;

    localparam logic [31:0] I_ADDI  = 32'h91000401;
    localparam logic [31:0] I_ADDS  = 32'hAB000000;
    localparam logic [31:0] I_SUBS  = 32'hEB000000;
    localparam logic [31:0] I_LDURB = 32'h38400000;
    localparam logic [31:0] I_STUR  = 32'hF8000000;
    localparam logic [31:0] I_BM2   = 32'h17FFFFFE;
    localparam logic [31:0] I_BLT3  = 32'h5400006B;
    localparam logic [31:0] I_BGT3  = 32'h5400006C;
    localparam logic [31:0] I_BEQ3  = 32'h54000060;
    localparam logic [31:0] I_CBZ2  = 32'hB4000040;

    pc_control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .Instruction  (Instruction),
        .instr_addr   (instr_addr),
        .negativeAlu  (negativeAlu),
        .zeroAlu      (zeroAlu),
        .overflowAlu  (overflowAlu),
        .carryOutAlu  (carryOutAlu),
        .zeroCurr     (zeroCurr),
        .Reg2Loc      (Reg2Loc),
        .ALUSrc       (ALUSrc),
        .imm12Cntrl   (imm12Cntrl),
        .movKCntrl    (movKCntrl),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .byteLoader   (byteLoader),
        .flagSignal   (flagSignal),
        .ALUop        (ALUop),
        .xfer_size    (xfer_size),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        Instruction = 32'h0;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        Instruction = I_ADDS;
        #1;
        checks++;
        if (RegWrite !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_regwrite got %b want 0", RegWrite);
        end
        checks++;
        if (flagSignal !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_flagsignal got %b want 0", flagSignal);
        end
        step();
        checks++;
        if (instr_addr !== 64'd0) begin
            fails++;
            $display("[TB] FAIL reset_pc got %h want 0", instr_addr);
        end
        checks++;
        if (halted !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_halted got %b want 0", halted);
        end
        checks++;
        if (instr_count !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset_count got %0d want 0", instr_count);
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_addi();
        Instruction = I_ADDI;
        #1;
        checks++;
        if ({RegWrite, imm12Cntrl, ALUSrc, ALUop, flagSignal} !== {1'b1, 1'b1, 1'b0, 3'b010, 1'b0}) begin
            fails++;
            $display("[TB] FAIL addi_ctrl got %b want 1100100",
                     {RegWrite, imm12Cntrl, ALUSrc, ALUop, flagSignal});
        end
        step();
        checks++;
        if (instr_addr !== 64'd4) begin
            fails++;
            $display("[TB] FAIL addi_pc got %h want 4", instr_addr);
        end
        checks++;
        if (instr_count !== 32'd1) begin
            fails++;
            $display("[TB] FAIL addi_count got %0d want 1", instr_count);
        end
    endtask

    task automatic test_branch();
        // PC is 4 here; one more ADDI reaches 8.
        Instruction = I_ADDI;
        step();
        Instruction = I_BM2;
        step();
        checks++;
        if (instr_addr !== 64'd0) begin
            fails++;
            $display("[TB] FAIL b_back_pc got %h want 0", instr_addr);
        end
        step();
        checks++;
        if (instr_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            fails++;
            $display("[TB] FAIL b_wrap_pc got %h want fffffffffffffff8", instr_addr);
        end
        checks++;
        if (instr_count !== 32'd4) begin
            fails++;
            $display("[TB] FAIL b_count got %0d want 4", instr_count);
        end
    endtask

    task automatic test_bcond();
        do_reset();
        negativeAlu = 1'b1;
        overflowAlu = 1'b0;
        zeroAlu     = 1'b0;
        Instruction = I_BLT3;
        step();
        checks++;
        if (instr_addr !== 64'd12) begin
            fails++;
            $display("[TB] FAIL blt_taken_pc got %h want c", instr_addr);
        end
        negativeAlu = 1'b0;
        step();
        checks++;
        if (instr_addr !== 64'd16) begin
            fails++;
            $display("[TB] FAIL blt_not_taken_pc got %h want 10", instr_addr);
        end
        zeroAlu     = 1'b1;
        Instruction = I_BGT3;
        step();
        checks++;
        if (instr_addr !== 64'd20) begin
            fails++;
            $display("[TB] FAIL bgt_zero_pc got %h want 14", instr_addr);
        end
        Instruction = I_BEQ3;
        step();
        checks++;
        if (instr_addr !== 64'd32) begin
            fails++;
            $display("[TB] FAIL beq_taken_pc got %h want 20", instr_addr);
        end
        zeroAlu = 1'b0;
    endtask

    task automatic test_cbz();
        do_reset();
        zeroCurr    = 1'b1;
        Instruction = I_CBZ2;
        #1;
        checks++;
        if ({RegWrite, write_enable, read_enable} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL cbz_taken_writes got %b want 000",
                     {RegWrite, write_enable, read_enable});
        end
        step();
        checks++;
        if (instr_addr !== 64'd8) begin
            fails++;
            $display("[TB] FAIL cbz_taken_pc got %h want 8", instr_addr);
        end
        zeroCurr = 1'b0;
        #1;
        checks++;
        if ({RegWrite, write_enable, read_enable} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL cbz_not_taken_writes got %b want 000",
                     {RegWrite, write_enable, read_enable});
        end
        step();
        checks++;
        if (instr_addr !== 64'd12) begin
            fails++;
            $display("[TB] FAIL cbz_not_taken_pc got %h want c", instr_addr);
        end
    endtask

    task automatic test_mem();
        Instruction = I_LDURB;
        #1;
        checks++;
        if ({xfer_size, byteLoader, MemtoReg, read_enable, RegWrite, ALUSrc} !== {4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            fails++;
            $display("[TB] FAIL ldurb_ctrl got %b want 000101111",
                     {xfer_size, byteLoader, MemtoReg, read_enable, RegWrite, ALUSrc});
        end
        Instruction = I_STUR;
        #1;
        checks++;
        if ({xfer_size, Reg2Loc, write_enable, RegWrite} !== {4'd8, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL stur_ctrl got %b want 1000010",
                     {xfer_size, Reg2Loc, write_enable, RegWrite});
        end
        Instruction = I_ADDS;
        #1;
        checks++;
        if ({Reg2Loc, ALUop, flagSignal, RegWrite} !== {1'b1, 3'b010, 1'b1, 1'b1}) begin
            fails++;
            $display("[TB] FAIL adds_ctrl got %b want 101011",
                     {Reg2Loc, ALUop, flagSignal, RegWrite});
        end
        Instruction = I_SUBS;
        #1;
        checks++;
        if (ALUop !== 3'b011) begin
            fails++;
            $display("[TB] FAIL subs_aluop got %b want 011", ALUop);
        end
    endtask

    task automatic test_halt();
        do_reset();
        Instruction = I_ADDI;
        for (int i = 0; i < 4; i++)
            step();
        checks++;
        if (instr_addr !== 64'd16) begin
            fails++;
            $display("[TB] FAIL halt_setup_pc got %h want 10", instr_addr);
        end
        Instruction = 32'h0;
        #1;
        checks++;
        if ({RegWrite, write_enable, read_enable, flagSignal} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL halt_entry_writes got %b want 0000",
                     {RegWrite, write_enable, read_enable, flagSignal});
        end
        step();
        checks++;
        if (halted !== 1'b1) begin
            fails++;
            $display("[TB] FAIL halt_flag got %b want 1", halted);
        end
        checks++;
        if (instr_addr !== 64'd16) begin
            fails++;
            $display("[TB] FAIL halt_pc got %h want 10", instr_addr);
        end
        checks++;
        if (instr_count !== 32'd4) begin
            fails++;
            $display("[TB] FAIL halt_count got %0d want 4", instr_count);
        end
        // A valid word while halted must stay inert.
        Instruction = I_ADDI;
        #1;
        checks++;
        if ({RegWrite, write_enable, read_enable, flagSignal} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL halted_writes got %b want 0000",
                     {RegWrite, write_enable, read_enable, flagSignal});
        end
        step();
        checks++;
        if (instr_addr !== 64'd16 || instr_count !== 32'd4 || halted !== 1'b1) begin
            fails++;
            $display("[TB] FAIL halted_hold got pc=%h cnt=%0d halted=%b want pc=10 cnt=4 halted=1",
                     instr_addr, instr_count, halted);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (instr_addr !== 64'd0 || halted !== 1'b0) begin
            fails++;
            $display("[TB] FAIL halt_reset got pc=%h halted=%b want pc=0 halted=0",
                     instr_addr, halted);
        end
    endtask

    initial begin
        checks      = 0;
        fails       = 0;
        reset       = 1'b1;
        Instruction = 32'h0;
        negativeAlu = 1'b0;
        zeroAlu     = 1'b0;
        overflowAlu = 1'b0;
        carryOutAlu = 1'b0;
        zeroCurr    = 1'b0;
        test_reset();
        test_addi();
        test_branch();
        test_bcond();
        test_cbz();
        test_mem();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
